// File: rtl/prog_loader_if.sv
// Byte-stream and instruction-memory write bus of the boot-time program loader.
// The loader attaches through the slave modport; the byte source / memory side uses master.
interface prog_loader_if #(
    parameter int ADDR_W = 4
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader: COUNT byte, N big-endian 16-bit words, optional XOR check byte.
// Define LOADER_CHECKSUM_EN to require and verify the trailing check byte (CHK state).
module prog_loader #(
    parameter int ADDR_W = 4,
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    prog_loader_if.slave      bus,
    input  logic              restart,
    output logic              core_rst_n,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [8:0] MAX_COUNT = 9'(2 ** ADDR_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_RUN,
        S_ERR
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    count_q;
    logic [ADDR_W-1:0]   index_q;
    logic [WORD_W/2-1:0] hi_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          chk_q;
`endif

    logic take;
    logic last_word;
    logic bad_count;

    assign take      = bus.rx_valid && bus.rx_ready;
    assign last_word = ({1'b0, index_q} == count_q - 1'b1);
    assign bad_count = (bus.rx_data == 8'd0) || ({1'b0, bus.rx_data} > MAX_COUNT);

    // Every output is a register updated together with the state, so rx_ready
    // is already low in the cycle that follows the last accepted byte.
    // NOTE: sequential state uses <= so every branch sees the pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            bus.rx_ready   <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            core_rst_n     <= 1'b0;
            load_done      <= 1'b0;
            load_err       <= 1'b0;
            words_loaded   <= '0;
            count_q        <= '0;
            index_q        <= '0;
            hi_q           <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk_q          <= '0;
`endif
        end else if (restart) begin
            // Wins over a coincident byte transfer; imem contents are kept.
            state        <= S_IDLE;
            bus.rx_ready <= 1'b1;
            bus.imem_we  <= 1'b0;
            core_rst_n   <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
            index_q      <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk_q        <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    bus.rx_ready <= 1'b1;
                    if (take) begin
                        if (bad_count) begin
                            state        <= S_ERR;
                            bus.rx_ready <= 1'b0;
                            load_err     <= 1'b1;
                        end else begin
                            state   <= S_HI;
                            count_q <= CNT_W'(bus.rx_data);
                            index_q <= '0;
`ifdef LOADER_CHECKSUM_EN
                            chk_q   <= bus.rx_data;
`endif
                        end
                    end
                end

                S_HI: begin
                    if (take) begin
                        state <= S_LO;
                        hi_q  <= bus.rx_data;
`ifdef LOADER_CHECKSUM_EN
                        chk_q <= chk_q ^ bus.rx_data;
`endif
                    end
                end

                S_LO: begin
                    if (take) begin
                        state          <= S_WRITE;
                        bus.rx_ready   <= 1'b0;
                        bus.imem_we    <= 1'b1;
                        bus.imem_addr  <= index_q;
                        bus.imem_wdata <= {hi_q, bus.rx_data};
`ifdef LOADER_CHECKSUM_EN
                        chk_q          <= chk_q ^ bus.rx_data;
`endif
                    end
                end

                S_WRITE: begin
                    bus.imem_we  <= 1'b0;
                    words_loaded <= words_loaded + 1'b1;
                    if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                        state        <= S_CHK;
                        bus.rx_ready <= 1'b1;
`else
                        state        <= S_RUN;
                        core_rst_n   <= 1'b1;
                        load_done    <= 1'b1;
`endif
                    end else begin
                        state        <= S_HI;
                        bus.rx_ready <= 1'b1;
                        index_q      <= index_q + 1'b1;
                    end
                end

`ifdef LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (take) begin
                        bus.rx_ready <= 1'b0;
                        if (bus.rx_data == chk_q) begin
                            state      <= S_RUN;
                            core_rst_n <= 1'b1;
                            load_done  <= 1'b1;
                        end else begin
                            state    <= S_ERR;
                            load_err <= 1'b1;
                        end
                    end
                end
`endif

                S_RUN, S_ERR: begin
                    bus.rx_ready <= 1'b0;
                end

                default: begin
                    state        <= S_IDLE;
                    bus.rx_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table vectors, hand sequences and random loads
// checked against a stream-level reference model (honours LOADER_CHECKSUM_EN).
module tb_prog_loader;
    localparam int ADDR_W = 4;
    localparam int CAP    = 1 << ADDR_W;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        string       name;
        logic [63:0] bytes;
        int          len;
        bit          exp_done;
        bit          exp_err;
        int          exp_words;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            restart = 1'b0;
    logic            core_rst_n;
    logic            load_done;
    logic            load_err;
    logic [ADDR_W:0] words_loaded;

    prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

    prog_loader #(.ADDR_W(ADDR_W), .WORD_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .restart      (restart),
        .core_rst_n   (core_rst_n),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [ADDR_W+15:0] wr_q[$];
    logic [ADDR_W+15:0] exp_wr[$];
    bit                 m_done, m_err;
    int                 m_send, m_words;
    vec_t               vecs[$];

    // Capture every write pulse; outputs only move on posedge.
    always @(negedge clk)
        if (bus.imem_we === 1'b1) wr_q.push_back({bus.imem_addr, bus.imem_wdata});

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Stream-level model: what the memory should see and how the load ends.
    function automatic void model(input byte_q_t s);
        int n;
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] x;
`endif
        exp_wr.delete();
        m_done = 0; m_err = 0; m_words = 0;
        n = int'(s[0]);
        if (n == 0 || n > CAP) begin
            m_err = 1; m_send = 1;
            return;
        end
        for (int i = 0; i < n; i++)
            exp_wr.push_back({ADDR_W'(i), s[1+2*i], s[2+2*i]});
        m_words = n;
`ifdef LOADER_CHECKSUM_EN
        x = s[0];
        for (int i = 1; i <= 2 * n; i++) x = x ^ s[i];
        m_send = 2 * n + 2;
        if (s[2*n+1] == x) m_done = 1; else m_err = 1;
`else
        m_send = 2 * n + 1;
        m_done = 1;
`endif
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int waited = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                bus.rx_valid = 1'b0;
                bus.rx_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (bus.rx_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (bus.rx_ready !== 1'b1) check("rx_ready_timeout", bus.rx_ready, 1);
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic do_restart(input string tag);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check({tag, ".rst.words"}, words_loaded, 0);
        check({tag, ".rst.done"}, load_done, 0);
        check({tag, ".rst.err"}, load_err, 0);
        check({tag, ".rst.core"}, core_rst_n, 0);
        check({tag, ".rst.ready"}, bus.rx_ready, 1);
    endtask

    task automatic run_load(input string tag, input byte_q_t s, input bit gaps,
                            input bit exp_done, input bit exp_err, input int exp_words);
        int w = 0;
        wr_q.delete();
        model(s);
        for (int i = 0; i < m_send; i++) send_byte(s[i], gaps);
        while (load_done !== 1'b1 && load_err !== 1'b1 && w < 8) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        check({tag, ".done"}, load_done, exp_done);
        check({tag, ".err"}, load_err, exp_err);
        check({tag, ".core"}, core_rst_n, exp_done);
        check({tag, ".ready"}, bus.rx_ready, 0);
        check({tag, ".words"}, words_loaded, exp_words);
        check({tag, ".nwr"}, wr_q.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++)
            check($sformatf("%s.wr%0d", tag, i), wr_q[i], exp_wr[i]);
        do_restart(tag);
    endtask

    function automatic void add_vec(input string name, input logic [63:0] bytes, input int len,
                                    input bit d, input bit e, input int words);
        vec_t v;
        v.name = name; v.bytes = bytes; v.len = len;
        v.exp_done = d; v.exp_err = e; v.exp_words = words;
        vecs.push_back(v);
    endfunction

    initial begin
        byte_q_t s;
        logic [7:0] x;

`ifdef LOADER_CHECKSUM_EN
        add_vec("good2",   64'h021234ABCD420000, 6, 1, 0, 2);
        add_vec("badchk",  64'h021234ABCD430000, 6, 0, 1, 2);
        add_vec("one",     64'h01BEEF5000000000, 4, 1, 0, 1);
`else
        add_vec("good2",   64'h021234ABCD000000, 5, 1, 0, 2);
        add_vec("one",     64'h01BEEF0000000000, 3, 1, 0, 1);
`endif
        add_vec("count0",  64'h0000000000000000, 1, 0, 1, 0);
        add_vec("count17", 64'h1100000000000000, 1, 0, 1, 0);

        // Reset behaviour
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.ready", bus.rx_ready, 0);
        check("reset.we", bus.imem_we, 0);
        check("reset.addr", bus.imem_addr, 0);
        check("reset.wdata", bus.imem_wdata, 0);
        check("reset.words", words_loaded, 0);
        check("reset.done", load_done, 0);
        check("reset.err", load_err, 0);
        check("reset.core", core_rst_n, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset.ready", bus.rx_ready, 1);
        check("post_reset.core", core_rst_n, 0);

        // Table vectors
        foreach (vecs[k]) begin
            s.delete();
            for (int i = 0; i < vecs[k].len; i++) s.push_back(vecs[k].bytes[63-8*i -: 8]);
            run_load(vecs[k].name, s, 1'b0, vecs[k].exp_done, vecs[k].exp_err, vecs[k].exp_words);
        end

        // Restart coincident with a valid byte mid-load
        wr_q.delete();
        send_byte(8'h03, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        @(negedge clk);
        check("abort.words_before", words_loaded, 1);
        check("abort.ready_before", bus.rx_ready, 1);
        bus.rx_data  = 8'hCC;
        bus.rx_valid = 1'b1;
        restart      = 1'b1;
        @(negedge clk);
        restart      = 1'b0;
        bus.rx_valid = 1'b0;
        check("abort.words", words_loaded, 0);
        check("abort.ready", bus.rx_ready, 1);
        check("abort.err", load_err, 0);
        check("abort.nwr", wr_q.size(), 1);
        if (wr_q.size() > 0) check("abort.wr0", wr_q[0], {4'd0, 16'hAABB});
        s = '{8'h01, 8'hBE, 8'hEF};
`ifdef LOADER_CHECKSUM_EN
        s.push_back(8'h50);
`endif
        run_load("reload", s, 1'b0, 1, 0, 1);

        // Full-capacity load with gaps: no address wrap
        s.delete();
        s.push_back(8'h10);
        for (int i = 0; i < CAP; i++) begin
            s.push_back(8'h00);
            s.push_back(8'(i));
        end
`ifdef LOADER_CHECKSUM_EN
        s.push_back(8'h10);
`endif
        run_load("full16", s, 1'b1, 1, 0, CAP);

        // Random loads against the model
        for (int t = 0; t < 25; t++) begin
            int n;
            if ($urandom_range(0, 4) == 0)
                n = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(CAP + 1, 255));
            else
                n = int'($urandom_range(1, CAP));
            s.delete();
            s.push_back(8'(n));
            x = 8'(n);
            if (n >= 1 && n <= CAP) begin
                for (int i = 0; i < 2 * n; i++) begin
                    s.push_back(8'($urandom));
                    x = x ^ s[s.size()-1];
                end
`ifdef LOADER_CHECKSUM_EN
                s.push_back(($urandom_range(0, 3) == 0) ? (x ^ 8'(1 << $urandom_range(0, 7))) : x);
`endif
            end
            model(s);
            run_load($sformatf("rnd%0d", t), s, 1'b1, m_done, m_err, m_words);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
